asconp_iter: RTL
================

# asconp_iter

Iterative round controller for the Ascon permutation datapath. It holds the 320-bit Ascon state in registers and accepts a load or XOR-absorb request through a valid/ready handshake. It then drives the combinational `asconp` core for the requested number of rounds, UROL rounds per cycle, and presents the permuted state through a second valid/ready handshake. It sits directly around `asconp`: it feeds `x0_i..x4_i` and `round_cnt`, and registers `x0_o..x4_o` every cycle.

## Interface
- UROL, from config.sv (global, not overridable here): rounds per cycle; legal values 1, 2, 3, 4, 6.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_mode  in  1  0 = load: state <= in_x*. 1 = absorb: state <= state ^ in_x*.
- in_rounds  in  4  number of rounds, 1..12.
- in_x0..in_x4  in  64 each  input state words.
- out_valid  out  1  permuted state available.
- out_ready  in  1  consumer accepts.
- out_x0..out_x4  out  64 each  state register contents; valid while out_valid=1.
- err  out  1  one-cycle pulse on a rejected request.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & legal in_rounds: apply in_mode to the state registers, set round_cnt <= in_rounds, go to RUN.
  - On in_valid & illegal in_rounds: pulse err for one cycle, leave state unchanged, stay in IDLE; the request counts as consumed.
- Legal in_rounds: 1 <= in_rounds <= 12 and in_rounds % UROL == 0. Zero is illegal.
- RUN:
  - Each cycle: state <= asconp(state, round_cnt); round_cnt <= round_cnt - UROL (4-bit, no wrap occurs for legal requests).
  - When the pre-update round_cnt == UROL, that cycle is the final one; go to DONE.
- Round constants are generated inside `asconp` from round_cnt. Starting at round_cnt = in_rounds yields standard Ascon constants: 12 gives first constant 0xF0; 8 gives 0xB4; 6 gives 0x96.
- DONE:
  - out_valid=1.
  - On out_ready: go to IDLE. The state register is retained, so a following absorb XORs into the permuted state.
- out_x* always reflect the state register and are stable throughout DONE.
- in_* are ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE; state registers 0; round_cnt 0.
  - in_ready=1, out_valid=0, err=0, out_x*=0.
- Reset mid-RUN or mid-DONE aborts immediately with the same result. No partial output is produced.
- Latency: request accepted at edge N. RUN occupies edges N+1 .. N+in_rounds/UROL. out_valid is high from the cycle after edge N+in_rounds/UROL.
  - Example, UROL=1, p12: out_valid rises 12 cycles after acceptance.
- Throughput: no overlap. The next request is accepted no earlier than the cycle after the output handshake, giving a minimum of in_rounds/UROL + 2 cycles per permutation.
- in_ready and out_valid are never high simultaneously.
- err is registered and is high exactly one cycle after the rejecting edge.
- in_ready, out_valid and err are functions of FSM state only. There is no combinational path from in_valid or out_ready.

## Test plan
- Reset behaviour: assert rst_n=0 for 2 cycles with in_valid=1 and nonzero inputs -> out_x*=0, in_ready=1, out_valid=0, err=0.
- p12 load:
  - Stimulus: load x0=0x80400C0600000000, x1..x4=0, in_rounds=12, UROL=1.
  - Required: out_valid rises exactly 12 cycles after acceptance; out_x* match the C reference Ascon-p12.
  - Repeat for in_rounds 8 and 6.
- Absorb chaining:
  - Stimulus: load+p12, then absorb x0=0x0123456789ABCDEF with x1..x4=0 and in_rounds=6.
  - Required: result equals the reference p6(p12(S) ^ (x0 word)).
- Output backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_x* constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Illegal rounds:
  - in_rounds=0 -> err pulse, state unchanged, FSM stays in IDLE.
  - in_rounds=13 -> same as 0.
  - in_rounds=8 with UROL=3 -> same as 0.
  - A legal request on the next cycle is accepted normally.
- Reset mid-RUN: assert rst_n=0 at the 5th RUN cycle of a p12 -> next cycle IDLE, state=0, no out_valid pulse.

Source files
------------

// File: rtl/asconp_iter_if.sv
// Request/response bundle between an Ascon permutation client and asconp_iter.
// The master drives requests and output acceptance; the slave is the round controller.
interface asconp_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [3:0]  in_rounds;
    logic [63:0] in_x0;
    logic [63:0] in_x1;
    logic [63:0] in_x2;
    logic [63:0] in_x3;
    logic [63:0] in_x4;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_x0;
    logic [63:0] out_x1;
    logic [63:0] out_x2;
    logic [63:0] out_x3;
    logic [63:0] out_x4;
    logic        err;

    modport master (
        output in_valid, in_mode, in_rounds, in_x0, in_x1, in_x2, in_x3, in_x4, out_ready,
        input  in_ready, out_valid, out_x0, out_x1, out_x2, out_x3, out_x4, err
    );

    modport slave (
        input  in_valid, in_mode, in_rounds, in_x0, in_x1, in_x2, in_x3, in_x4, out_ready,
        output in_ready, out_valid, out_x0, out_x1, out_x2, out_x3, out_x4, err
    );
endinterface

// File: rtl/asconp_iter.sv
// Iterative Ascon permutation: a combinational UROL-round core (asconp) wrapped by a
// load/absorb -> run -> present controller that owns the 320-bit state register.
package asconp_config_pkg;
    // Rounds evaluated per clock; legal values 1, 2, 3, 4, 6.
    localparam int UROL = 1;

    // Word i of the Ascon state is element i (x0 in the low 64 bits).
    typedef logic [4:0][63:0] ascon_state_t;
endpackage

module asconp
    import asconp_config_pkg::*;
(
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    input  logic [3:0]  round_cnt,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o
);
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // round_cnt counts remaining rounds, so round index = 12 - round_cnt.
    function automatic logic [7:0] round_const(input logic [3:0] rc);
        return {4'(rc + 4'd3), 4'(4'd12 - rc)};
    endfunction

    function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [7:0] rc);
        ascon_state_t x;
        ascon_state_t t;
        x    = s;
        x[2] = x[2] ^ {56'd0, rc};
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        // Chi-style core of the 5-bit S-box, applied bit-sliced across all 64 columns.
        for (int i = 0; i < 5; i++) begin
            t[i] = x[i] ^ (~x[(i + 1) % 5] & x[(i + 2) % 5]);
        end
        t[1] = t[1] ^ t[0];
        t[0] = t[0] ^ t[4];
        t[3] = t[3] ^ t[2];
        t[2] = ~t[2];
        for (int i = 0; i < 5; i++) begin
            x[i] = t[i] ^ ror64(t[i], ROT_A[i]) ^ ror64(t[i], ROT_B[i]);
        end
        return x;
    endfunction

    ascon_state_t s;

    // NOTE: blocking assignments here are deliberate; each unrolled round must see the
    // previous round's result within the same evaluation, which <= would not provide.
    always_comb begin
        s = {x4_i, x3_i, x2_i, x1_i, x0_i};
        for (int r = 0; r < UROL; r++) begin
            s = ascon_round(s, round_const(round_cnt - 4'(r)));
        end
    end

    assign x0_o = s[0];
    assign x1_o = s[1];
    assign x2_o = s[2];
    assign x3_o = s[3];
    assign x4_o = s[4];
endmodule

module asconp_iter
    import asconp_config_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    asconp_iter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    function automatic logic [15:0] legal_mask();
        logic [15:0] m;
        for (int r = 0; r < 16; r++) begin
            m[r] = (r >= 1) && (r <= 12) && ((r % UROL) == 0);
        end
        return m;
    endfunction

    localparam logic [15:0] LEGAL_ROUNDS = legal_mask();
    localparam logic [3:0]  STEP         = 4'(UROL);

    fsm_t         fsm;
    ascon_state_t state;
    ascon_state_t perm;
    ascon_state_t in_word;
    logic [3:0]   round_cnt;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         err_q;

    assign in_word = {bus.in_x4, bus.in_x3, bus.in_x2, bus.in_x1, bus.in_x0};

    asconp u_core (
        .x0_i      (state[0]),
        .x1_i      (state[1]),
        .x2_i      (state[2]),
        .x3_i      (state[3]),
        .x4_i      (state[4]),
        .round_cnt (round_cnt),
        .x0_o      (perm[0]),
        .x1_o      (perm[1]),
        .x2_o      (perm[2]),
        .x3_o      (perm[3]),
        .x4_o      (perm[4])
    );

    // Handshake outputs are registered alongside the state so they depend on FSM state only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            // NOTE: the state register is cleared on reset because out_x* are architecturally
            // visible and must read zero after reset, not whatever was left mid-permutation.
            state       <= '0;
            round_cnt   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (LEGAL_ROUNDS[bus.in_rounds]) begin
                            state      <= bus.in_mode ? (state ^ in_word) : in_word;
                            round_cnt  <= bus.in_rounds;
                            in_ready_q <= 1'b0;
                            fsm        <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    state     <= perm;
                    round_cnt <= round_cnt - STEP;
                    if (round_cnt == STEP) begin
                        out_valid_q <= 1'b1;
                        fsm         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm         <= IDLE;
                    end
                end
                default: begin
                    fsm         <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.out_x0    = state[0];
    assign bus.out_x1    = state[1];
    assign bus.out_x2    = state[2];
    assign bus.out_x3    = state[3];
    assign bus.out_x4    = state[4];
endmodule
